// File: rtl/uart_pkg.sv
// uart_pkg: FSM encodings, header tag and source-id width shared by the UART TX arbiter.
// The CHK encoding exists only when UART_ARB_CHECKSUM_EN is defined.
package uart_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HDR  = 2'd1;
   localparam logic [1:0] PAY  = 2'd2;
`ifdef UART_ARB_CHECKSUM_EN
   localparam logic [1:0] CHK  = 2'd3;
`endif
   localparam logic [3:0] HDR_TAG  = 4'hA;
   localparam int         SRC_ID_W = 4;

   function automatic logic [7:0] hdr_byte(input logic [SRC_ID_W-1:0] id);
      return {HDR_TAG, id};
   endfunction
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: round-robin pick among requesters, searching from last_grant+1 with wrap.
module uart_rr_arbiter #(
   parameter int N_SRC = 4,
   parameter int IW    = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic [N_SRC-1:0] grant,
   output logic [IW-1:0]    index
);
   logic          found;
   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 1; i <= N_SRC; i++) begin
         sum = {1'b0, last_grant} + (IW+1)'(i);
         idx = sum >= (IW+1)'(N_SRC) ? IW'(sum - (IW+1)'(N_SRC)) : sum[IW-1:0];
         if (!found && req[idx]) begin
            found = 1'b1;
            index = idx;
         end
      end
      grant[index] = found;
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frames round-robin granted source bytes as {header, payload} packets into a UART TX FIFO.
// Define UART_ARB_CHECKSUM_EN to append a header^payload checksum byte to each packet.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_SRC = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_SRC-1:0]      req,
   input  logic [N_SRC-1:0][7:0] src_data,
   output logic [N_SRC-1:0]      ack,
   input  logic                  tx_full,
   output logic                  wr_uart,
   output logic [7:0]            w_data
);
   localparam int IW = $clog2(N_SRC);

   logic [1:0]          state;
   logic [IW-1:0]       last_grant;
   logic [SRC_ID_W-1:0] id;
   logic [7:0]          payload;
   logic [N_SRC-1:0]    gnt;
   logic [IW-1:0]       gidx;
   logic                can_wr;

   uart_rr_arbiter #(.N_SRC(N_SRC), .IW(IW)) u_rr (
      .req        (req),
      .last_grant (last_grant),
      .grant      (gnt),
      .index      (gidx)
   );

   // a strobe in the previous cycle blocks this one, keeping bytes at least two cycles apart
   assign can_wr = !tx_full && !wr_uart;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ack        <= '0;
         wr_uart    <= 1'b0;
         w_data     <= 8'h00;
         last_grant <= IW'(N_SRC - 1);
         id         <= '0;
         payload    <= 8'h00;
      end else begin
         ack     <= '0;
         wr_uart <= 1'b0;
         case (state)
            IDLE: if (|req) begin
               ack        <= gnt;
               last_grant <= gidx;
               id         <= SRC_ID_W'(gidx);
               payload    <= src_data[gidx];
               state      <= HDR;
            end
            HDR: if (can_wr) begin
               wr_uart <= 1'b1;
               w_data  <= hdr_byte(id);
               state   <= PAY;
            end
            PAY: if (can_wr) begin
               wr_uart <= 1'b1;
               w_data  <= payload;
`ifdef UART_ARB_CHECKSUM_EN
               state   <= CHK;
`else
               state   <= IDLE;
`endif
            end
`ifdef UART_ARB_CHECKSUM_EN
            CHK: if (can_wr) begin
               wr_uart <= 1'b1;
               w_data  <= hdr_byte(id) ^ payload;
               state   <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of framing, round-robin order, stalls and reset abort.
// Packet length follows UART_ARB_CHECKSUM_EN.
module tb_uart_tx_arbiter;
   localparam int N = 4;
`ifdef UART_ARB_CHECKSUM_EN
   localparam int PKT = 3;
`else
   localparam int PKT = 2;
`endif

   logic              clk = 1'b0, rst = 1'b1, tx_full = 1'b0, wr_uart;
   logic [N-1:0]      req = '0, ack;
   logic [N-1:0][7:0] src_data = '0;
   logic [7:0]        w_data;
   int                n_checks = 0, n_fail = 0, viol_b2b = 0, viol_tf = 0;
   logic              wr_q = 1'b0, tf_q = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_SRC(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .src_data (src_data),
      .ack      (ack),
      .tx_full  (tx_full),
      .wr_uart  (wr_uart),
      .w_data   (w_data)
   );

   // protocol watch: no back-to-back strobes, no strobe right after tx_full was sampled high
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_q && wr_uart) viol_b2b <= viol_b2b + 1;
         if (tf_q && wr_uart) viol_tf <= viol_tf + 1;
      end
      wr_q <= wr_uart;
      tf_q <= tx_full;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; tx_full = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic get_packet(output logic [7:0] h, output logic [7:0] p, output logic [7:0] c, output bit ok);
      int w;
      ok = 1'b1; h = 'x; p = 'x; c = 'x;
      for (int k = 0; k < PKT; k++) begin
         w = 0;
         do begin step(); w++; end while (!wr_uart && w < 20);
         if (!wr_uart) ok = 1'b0;
         if (k == 0) h = w_data; else if (k == 1) p = w_data; else c = w_data;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
      n_checks++; if (wr_uart !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", wr_uart); end
      n_checks++; if (w_data !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", w_data); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      src_data[0] = 8'h5C; req = 4'b0001;
      step();
      n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", ack); end
      n_checks++; if (wr_uart !== 1'b0) begin n_fail++; $display("FAIL single_no_early_wr: got %b want 0", wr_uart); end
      req = '0;
      step();
      n_checks++; if ({wr_uart, w_data} !== 9'h1A0) begin n_fail++; $display("FAIL single_hdr: got %b/%h want 1/a0", wr_uart, w_data); end
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
      step();
      n_checks++; if ({wr_uart, w_data} !== 9'h0A0) begin n_fail++; $display("FAIL single_gap_hold: got %b/%h want 0/a0", wr_uart, w_data); end
      step();
      n_checks++; if ({wr_uart, w_data} !== 9'h15C) begin n_fail++; $display("FAIL single_pay: got %b/%h want 1/5c", wr_uart, w_data); end
`ifdef UART_ARB_CHECKSUM_EN
      step(); step();
      n_checks++; if ({wr_uart, w_data} !== 9'h1FC) begin n_fail++; $display("FAIL single_chk: got %b/%h want 1/fc", wr_uart, w_data); end
`endif
      step(); step();
      n_checks++; if ({wr_uart, ack} !== 5'b0_0000) begin n_fail++; $display("FAIL single_idle: wr %b ack %b want 0/0000", wr_uart, ack); end
   endtask

   task automatic test_round_robin();
      logic [7:0] h, p, c, eh, ep;
      bit ok;
      do_reset();
      for (int i = 0; i < N; i++) src_data[i] = 8'h10 + 8'(i);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         get_packet(h, p, c, ok);
         eh = {4'hA, 4'(i % N)};
         ep = 8'h10 + 8'(i % N);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_timeout pkt %0d: got no strobe want strobe", i); end
         n_checks++; if (h !== eh) begin n_fail++; $display("FAIL rr_hdr pkt %0d: got %h want %h", i, h, eh); end
         n_checks++; if (p !== ep) begin n_fail++; $display("FAIL rr_pay pkt %0d: got %h want %h", i, p, ep); end
`ifdef UART_ARB_CHECKSUM_EN
         n_checks++; if (c !== (eh ^ ep)) begin n_fail++; $display("FAIL rr_chk pkt %0d: got %h want %h", i, c, eh ^ ep); end
`endif
      end
      req = '0;
   endtask

   task automatic test_stall();
      int strobes;
      do_reset();
      src_data[0] = 8'h77; req = 4'b0001;
      step();
      n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL stall_ack: got %b want 0001", ack); end
      req = '0; tx_full = 1'b1; strobes = 0;
      repeat (5) begin step(); if (wr_uart) strobes++; end
      n_checks++; if (strobes !== 0) begin n_fail++; $display("FAIL stall_no_wr: got %0d strobes want 0", strobes); end
      tx_full = 1'b0;
      step();
      n_checks++; if ({wr_uart, w_data} !== 9'h1A0) begin n_fail++; $display("FAIL stall_hdr: got %b/%h want 1/a0", wr_uart, w_data); end
      step();
      n_checks++; if (wr_uart !== 1'b0) begin n_fail++; $display("FAIL stall_single_hdr: got %b want 0", wr_uart); end
      step();
      n_checks++; if ({wr_uart, w_data} !== 9'h177) begin n_fail++; $display("FAIL stall_pay: got %b/%h want 1/77", wr_uart, w_data); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] h, p, c;
      bit ok;
      do_reset();
      src_data[0] = 8'h99; req = 4'b0001;
      step();
      req = '0;
      step();
      n_checks++; if ({wr_uart, w_data} !== 9'h1A0) begin n_fail++; $display("FAIL rmid_hdr: got %b/%h want 1/a0", wr_uart, w_data); end
      step();
      rst = 1'b1;
      step();
      n_checks++; if ({wr_uart, w_data} !== 9'h000) begin n_fail++; $display("FAIL rmid_abort: got %b/%h want 0/00", wr_uart, w_data); end
      step();
      n_checks++; if (wr_uart !== 1'b0) begin n_fail++; $display("FAIL rmid_hold: got %b want 0", wr_uart); end
      rst = 1'b0; src_data[3] = 8'h3C; req = 4'b1000;
      get_packet(h, p, c, ok);
      req = '0;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout: got no strobe want strobe"); end
      n_checks++; if (h !== 8'hA3) begin n_fail++; $display("FAIL rmid_hdr_after: got %h want a3", h); end
      n_checks++; if (p !== 8'h3C) begin n_fail++; $display("FAIL rmid_pay_after: got %h want 3c", p); end
   endtask

   task automatic test_rr_pair();
      logic [7:0] h, p, c;
      logic [7:0] eh[3] = '{8'hA1, 8'hA2, 8'hA1};
      logic [7:0] ep[3] = '{8'h21, 8'h22, 8'h21};
      bit ok;
      src_data[1] = 8'h21; src_data[2] = 8'h22; req = 4'b0010;
      step();
      n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL pair_ack: got %b want 0010", ack); end
      req = 4'b0110;
      for (int i = 0; i < 3; i++) begin
         get_packet(h, p, c, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL pair_timeout pkt %0d: got no strobe want strobe", i); end
         n_checks++; if (h !== eh[i]) begin n_fail++; $display("FAIL pair_hdr pkt %0d: got %h want %h", i, h, eh[i]); end
         n_checks++; if (p !== ep[i]) begin n_fail++; $display("FAIL pair_pay pkt %0d: got %h want %h", i, p, ep[i]); end
      end
      req = '0;
   endtask

   task automatic test_hold_single();
      logic [7:0] h, p, c;
      bit ok;
      do_reset();
      src_data[2] = 8'h42; req = 4'b0100;
      for (int i = 0; i < 2; i++) begin
         get_packet(h, p, c, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_timeout pkt %0d: got no strobe want strobe", i); end
         n_checks++; if ({h, p} !== 16'hA242) begin n_fail++; $display("FAIL hold_pkt %0d: got %h%h want a242", i, h, p); end
      end
      req = '0;
   endtask

   task automatic test_protocol();
      step(); step();
      n_checks++; if (viol_b2b !== 0) begin n_fail++; $display("FAIL proto_back_to_back: got %0d violations want 0", viol_b2b); end
      n_checks++; if (viol_tf !== 0) begin n_fail++; $display("FAIL proto_after_full: got %0d violations want 0", viol_tf); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_reset_mid();
      test_rr_pair();
      test_hold_single();
      test_protocol();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, meaning number of requesters (2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port req  input  N_SRC  per-source request, level, held until ack.
REQ-005 SHALL have port src_data  input  N_SRC x 8  per-source payload byte, valid while req high.
REQ-006 SHALL have port ack  output  N_SRC  one-hot, one-cycle pulse; payload of that source captured.
REQ-007 SHALL have port tx_full  input  1  UART TX FIFO full.
REQ-008 SHALL have port wr_uart  output  1  one-cycle write strobe to the TX FIFO.
REQ-009 SHALL have port w_data  output  8  byte written when wr_uart high.

Function
REQ-010 SHALL frame each grant as a packet: header byte {4'hA, src_id[3:0]}, then payload byte.
REQ-011 SHALL implement FSM states IDLE, HDR, PAY (and CHK, see REQ-024); all outputs registered.
REQ-012 IDLE: any req high -> grant one source, latch its src_data and id, pulse its ack next cycle, go HDR.
REQ-013 Arbitration SHALL be round-robin: search starts at last_grant+1, wrapping N_SRC-1 -> 0.
REQ-014 HDR: when tx_full low, next cycle wr_uart=1, w_data=header, go PAY; when tx_full high, hold, wr_uart=0.
REQ-015 PAY: when tx_full low, next cycle wr_uart=1, w_data=latched payload, go IDLE (or CHK); else hold.
REQ-016 wr_uart SHALL never be high in two consecutive cycles; at most one byte per two cycles.
REQ-017 wr_uart SHALL never assert in the cycle after tx_full was sampled high.
REQ-018 Latency: req sampled at cycle t in IDLE, tx_full low -> ack at t+1, header strobe at t+2, payload strobe at t+4.
REQ-019 req changes of a source after its ack SHALL not affect the packet in flight; requests arriving mid-packet wait for IDLE.
REQ-020 IDLE SHALL last at least one cycle between packets; w_data holds its last value when wr_uart low.
REQ-021 Single requester held continuously SHALL be re-granted each packet; with all requesting, grants rotate 0,1,2,3,0...

Reset
REQ-022 On rst: state IDLE, ack=0, wr_uart=0, w_data=8'h00, last_grant=N_SRC-1 (source 0 first).
REQ-023 rst mid-packet SHALL abort the packet; no further byte of it is written, no replay.

Configuration
REQ-024 With macro UART_ARB_CHECKSUM_EN defined: PAY -> CHK; CHK writes header XOR payload under the same tx_full rule, then IDLE.
REQ-025 Without UART_ARB_CHECKSUM_EN: CHK state and checksum logic absent; packets are 2 bytes.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state enum, HDR_TAG (4'hA) and SRC_ID_W (4).
REQ-027 Round-robin selection SHALL be a sub-module uart_rr_arbiter (req, last_grant in; one-hot grant, index out).

Verification
REQ-028 req=4'b0001, src_data[0]=8'h5C, tx_full=0 -> ack[0] pulse; bytes 8'hA0, 8'h5C (plus 8'hFC with checksum).
REQ-029 req=4'b1111 held, data 8'h10..8'h13 -> headers A0,A1,A2,A3,A0 in order with matching payloads.
REQ-030 tx_full=1 for 5 cycles during HDR -> no wr_uart during stall; header written once, first cycle after release + 1.
REQ-031 rst asserted in PAY -> no payload byte written; after reset req=4'b1000 -> header 8'hA3.
REQ-032 req=4'b0110 after grant of 1 -> next grant source 2, then 1; no strobe ever back-to-back.
